// File: rtl/iibg_pingpong.sv
// Integral-image buffer generator: builds the integral image of a raster window on the fly
// into one of two banks while the classifier reads the other.
module iibg_pingpong #(
    parameter  int unsigned WIN   = 23,
    parameter  int unsigned PIX_W = 8,
    parameter  int unsigned II_W  = 21,
    localparam int unsigned AW    = $clog2(WIN * WIN)
) (
    input  logic            iClk,
    input  logic            iReset_n,
    input  logic            iRst,
    input  logic            iWrreq,
    input  logic [PIX_W-1:0] iData_in,
    output logic            oFull,
    input  logic            iRdreq,
    input  logic [AW-1:0]   iAddr_read,
    input  logic            iRelease,
    output logic            oReady,
    output logic [II_W-1:0] oData,
    output logic            oValid
);

    localparam int unsigned DEPTH = WIN * WIN;
    localparam int unsigned CW    = $clog2(WIN);
    localparam logic [CW-1:0] LAST = CW'(WIN - 1);

    logic [CW-1:0]   col;
    logic [CW-1:0]   row;
    logic [II_W-1:0] racc;
    logic [1:0]      bankFull;
    logic            wBank;
    logic            rBank;

    logic [II_W-1:0] lineReg [WIN];
    logic [II_W-1:0] mem [2][DEPTH];

    logic            wrAcc;
    logic            rdAcc;
    logic            relAcc;
    logic            lastCol;
    logic            lastPix;
    logic            rdInRange;
    logic [II_W-1:0] pix;
    logic [II_W-1:0] iiVal;
    logic [AW-1:0]   wAddr;
    logic [AW-1:0]   rdIdx;
    logic [1:0]      bankFullNext;

    assign oFull  = bankFull[wBank];
    assign oReady = bankFull[rBank];

    // Accept decisions, the new integral value and the bank-occupancy update.
    always_comb begin
        wrAcc        = iWrreq && !oFull;
        rdAcc        = iRdreq && oReady;
        relAcc       = iRelease && oReady;
        lastCol      = (col == LAST);
        lastPix      = lastCol && (row == LAST);
        pix          = II_W'(iData_in);
        iiVal        = ((row == '0) ? '0 : lineReg[col]) + racc + pix;
        wAddr        = AW'(row) * AW'(WIN) + AW'(col);
        rdInRange    = 32'(iAddr_read) < 32'(DEPTH);
        rdIdx        = rdInRange ? iAddr_read : '0;
        bankFullNext = bankFull;
        if (wrAcc && lastPix) begin
            bankFullNext[wBank] = 1'b1;
        end
        // A release always targets the other bank than a completing write.
        if (relAcc) begin
            bankFullNext[rBank] = 1'b0;
        end
    end

    // Storage has no reset: row 0 never consumes the line registers.
    always_ff @(posedge iClk) begin
        if (wrAcc && !iRst) begin
            mem[wBank][wAddr] <= iiVal;
            lineReg[col]      <= iiVal;
        end
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            col      <= '0;
            row      <= '0;
            racc     <= '0;
            bankFull <= '0;
            wBank    <= 1'b0;
            rBank    <= 1'b0;
            oValid   <= 1'b0;
            oData    <= '0;
        end else if (iRst) begin
            col      <= '0;
            row      <= '0;
            racc     <= '0;
            bankFull <= '0;
            wBank    <= 1'b0;
            rBank    <= 1'b0;
            oValid   <= 1'b0;
            oData    <= '0;
        end else begin
            if (wrAcc) begin
                racc <= lastCol ? '0 : racc + pix;
                col  <= lastCol ? '0 : col + CW'(1);
                if (lastCol) begin
                    row <= lastPix ? '0 : row + CW'(1);
                end
                if (lastPix) begin
                    wBank <= ~wBank;
                end
            end
            bankFull <= bankFullNext;
            if (relAcc) begin
                rBank <= ~rBank;
            end
            oValid <= rdAcc;
            if (rdAcc) begin
                oData <= rdInRange ? mem[rBank][rdIdx] : '0;
            end
        end
    end

endmodule

// File: tb/tb_iibg_pingpong.sv
// Randomized and directed bench for iibg_pingpong (WIN=3, 8-bit integral values) against a
// window-FIFO reference model that computes integrals as rectangle sums.
module tb_iibg_pingpong;

    localparam int unsigned WIN   = 3;
    localparam int unsigned PIX_W = 8;
    localparam int unsigned II_W  = 8;
    localparam int unsigned AW    = $clog2(WIN * WIN);

    logic            iClk;
    logic            iReset_n;
    logic            iRst;
    logic            iWrreq;
    logic [PIX_W-1:0] iData_in;
    logic            oFull;
    logic            iRdreq;
    logic [AW-1:0]   iAddr_read;
    logic            iRelease;
    logic            oReady;
    logic [II_W-1:0] oData;
    logic            oValid;

    iibg_pingpong #(.WIN(WIN), .PIX_W(PIX_W), .II_W(II_W)) dut (
        .iClk(iClk), .iReset_n(iReset_n), .iRst(iRst),
        .iWrreq(iWrreq), .iData_in(iData_in), .oFull(oFull),
        .iRdreq(iRdreq), .iAddr_read(iAddr_read), .iRelease(iRelease),
        .oReady(oReady), .oData(oData), .oValid(oValid)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    typedef logic [7:0] win_t [9];

    // Reference model: completed windows queue up (at most two), the front one is readable.
    win_t       fifo[$];
    win_t       cur;
    int         curCnt;
    logic [7:0] expData;
    bit         expValid;

    int total;
    int bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] integ(input win_t w, input int addr);
        int sum;
        if (addr >= 9) return 8'd0;
        sum = 0;
        for (int i = 0; i <= addr / 3; i++)
            for (int j = 0; j <= addr % 3; j++)
                sum += int'(w[i*3+j]);
        return 8'(sum);
    endfunction

    task automatic modelClear();
        fifo.delete();
        curCnt   = 0;
        expData  = 8'd0;
        expValid = 1'b0;
    endtask

    task automatic checkOuts(input string tag);
        chk({tag, ".full"},  32'(oFull),  32'(fifo.size() == 2));
        chk({tag, ".ready"}, 32'(oReady), 32'(fifo.size() > 0));
        chk({tag, ".valid"}, 32'(oValid), 32'(expValid));
        chk({tag, ".data"},  32'(oData),  32'(expData));
    endtask

    // One clock cycle of stimulus; the model advances alongside and outputs are checked after the edge.
    task automatic step(input bit wr, input logic [7:0] d, input bit rd, input logic [AW-1:0] a,
                        input bit rel, input string tag);
        bit wAcc, rAcc, relA;
        iWrreq = wr; iData_in = d; iRdreq = rd; iAddr_read = a; iRelease = rel;
        wAcc = wr && (fifo.size() < 2);
        rAcc = rd && (fifo.size() > 0);
        relA = rel && (fifo.size() > 0);
        if (rAcc) expData = integ(fifo[0], int'(a));
        expValid = rAcc;
        if (relA) void'(fifo.pop_front());
        if (wAcc) begin
            cur[curCnt] = d;
            curCnt++;
            if (curCnt == 9) begin
                fifo.push_back(cur);
                curCnt = 0;
            end
        end
        @(posedge iClk);
        #1;
        checkOuts(tag);
        iWrreq = 1'b0; iRdreq = 1'b0; iRelease = 1'b0;
    endtask

    task automatic writeN(input int n, input logic [7:0] d);
        for (int i = 0; i < n; i++) step(1'b1, d, 1'b0, '0, 1'b0, "wr");
    endtask

    task automatic rd(input logic [AW-1:0] a);
        step(1'b0, 8'd0, 1'b1, a, 1'b0, "rd");
    endtask

    task automatic rel();
        step(1'b0, 8'd0, 1'b0, '0, 1'b1, "rel");
    endtask

    initial begin
        total = 0; bad = 0;
        iReset_n = 1'b0; iRst = 1'b0; iWrreq = 1'b0; iData_in = '0;
        iRdreq = 1'b0; iAddr_read = '0; iRelease = 1'b0;
        modelClear();
        #12;
        checkOuts("reset");
        @(negedge iClk);
        iReset_n = 1'b1;
        @(posedge iClk); #1;

        // Nine 1s, then corner reads and an out-of-range address.
        writeN(9, 8'd1);
        rd(4'd0); rd(4'd4); rd(4'd8);
        chk("ones.a8", 32'(oData), 32'd9);
        rd(4'd9);
        chk("oor.valid", 32'(oValid), 32'd1);
        rel();

        // Pixels 1..9: every address of the read bank.
        for (int i = 1; i <= 9; i++) step(1'b1, 8'(i), 1'b0, '0, 1'b0, "ramp");
        for (int a = 0; a < 10; a++) rd(4'(a));
        rd(4'd8);
        chk("ramp.a8", 32'(oData), 32'd45);
        rel();

        // Ping-pong: two windows held, third-window pixel dropped.
        writeN(9, 8'd1);
        writeN(9, 8'd2);
        chk("pp.full", 32'(oFull), 32'd1);
        step(1'b1, 8'd7, 1'b0, '0, 1'b0, "drop");
        rel();
        chk("pp.ready", 32'(oReady), 32'd1);
        rd(4'd8);
        chk("pp.a8", 32'(oData), 32'd18);
        rel();
        chk("pp.empty", 32'({oReady, oFull}), 32'd0);

        // Overflow wraps modulo 256.
        writeN(9, 8'd255);
        rd(4'd8);
        chk("ovf.a8", 32'(oData), 32'd247);
        rel();

        // Synchronous clear mid-window.
        writeN(5, 8'd50);
        iRst = 1'b1;
        @(posedge iClk); #1;
        iRst = 1'b0;
        modelClear();
        checkOuts("srst");
        writeN(9, 8'd1);
        rd(4'd8);
        chk("srst.a8", 32'(oData), 32'd9);
        rel();

        // Asynchronous reset mid-cycle, outputs clear immediately.
        writeN(5, 8'd77);
        #2;
        iReset_n = 1'b0;
        #1;
        modelClear();
        checkOuts("arst");
        #1;
        iReset_n = 1'b1;
        @(posedge iClk); #1;
        writeN(9, 8'd1);
        rd(4'd8);
        chk("arst.a8", 32'(oData), 32'd9);
        rel();

        // Last pixel of window 2 together with release (and a read) of window 1.
        writeN(9, 8'd1);
        writeN(8, 8'd3);
        iWrreq = 1'b1; iData_in = 8'd3; iRelease = 1'b1;
        step(1'b1, 8'd3, 1'b1, 4'd8, 1'b1, "simul");
        chk("simul.rdold", 32'(oData), 32'd9);
        chk("simul.ready", 32'(oReady), 32'd1);
        chk("simul.full", 32'(oFull), 32'd0);
        rd(4'd8);
        chk("simul.a8", 32'(oData), 32'd27);
        rel();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 1) == 1,
                 4'($urandom_range(0, 15)), $urandom_range(0, 19) == 0, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
